// File: rtl/arp_tx_pkg.sv
// Shared ARP/Ethernet constants, state encoding and CRC-32 helpers,
// common to the ARP transmitter and receiver.
package arp_tx_pkg;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] HARD_TYPE     = 16'h0001;
  localparam logic [15:0] PROTOCOL_TYPE = 16'h0800;
  localparam logic [15:0] OP_REQ        = 16'h0001;
  localparam logic [15:0] OP_REP        = 16'h0002;
  localparam logic [7:0]  HARD_LEN      = 8'd6;
  localparam logic [7:0]  PROTO_LEN     = 8'd4;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hd5;

  localparam logic [31:0] CRC_INIT      = 32'hffff_ffff;
  localparam logic [31:0] CRC_POLY      = 32'h04c1_1db7;

  // Last byte-counter value in each state. IFG stops one short because the
  // registered GMII outputs add the final gap cycle.
  localparam logic [4:0]  PREAMBLE_LAST = 5'd7;
  localparam logic [4:0]  ETH_HEAD_LAST = 5'd13;
  localparam logic [4:0]  ARP_DATA_LAST = 5'd27;
  localparam logic [4:0]  PAD_LAST      = 5'd17;
  localparam logic [4:0]  FCS_LAST      = 5'd3;
  localparam logic [4:0]  IFG_LAST      = 5'd10;

  typedef enum logic [6:0] {
    ST_IDLE     = 7'b000_0001,
    ST_PREAMBLE = 7'b000_0010,
    ST_ETH_HEAD = 7'b000_0100,
    ST_ARP_DATA = 7'b000_1000,
    ST_PAD      = 7'b001_0000,
    ST_FCS      = 7'b010_0000,
    ST_IFG      = 7'b100_0000
  } arp_state_e;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Reflected (LSB-first) CRC-32 update for one data byte.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ reflect32(CRC_POLY);
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/arp_tx_crc32_d8.sv
// Byte-wide parallel CRC-32 register; clear has priority over enable.
module crc32_d8
  import arp_tx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i)     crc_d = CRC_INIT;
    else if (en_i) crc_d = crc32_byte(crc_q, data_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) crc_q <= CRC_INIT;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/arp_tx.sv
// ARP request/reply frame generator driving a GMII transmit port, one byte
// per cycle, with appended FCS and inter-frame gap.
module arp_tx
  import arp_tx_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h12_34_56_78_9a_bc,
  parameter logic [31:0] BOARD_IP  = {8'd0, 8'd0, 8'd0, 8'd0},
  parameter logic [47:0] DES_MAC   = 48'h2c_f0_5d_32_f1_07,
  parameter logic [31:0] DES_IP    = {8'd0, 8'd0, 8'd0, 8'd0}
)(
  input  logic        gmii_tx_clk,
  input  logic        rstn,
  input  logic        arp_tx_en,
  input  logic        arp_tx_type,
  input  logic [47:0] des_mac,
  input  logic [31:0] des_ip,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        tx_busy,
  output logic        tx_done
);

  arp_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        type_q, type_d;
  logic [47:0] mac_q, mac_d;
  logic [31:0] ip_q, ip_d;
  logic        txen_q, txen_d;
  logic [7:0]  txd_q, txd_d;
  logic        done_q, done_d;

  logic        crc_en, crc_clr;
  logic [31:0] crc_val;
  logic [111:0] eth_hdr, eth_sh;
  logic [223:0] arp_pkt, arp_sh;
  logic [31:0]  fcs_sh;

  // Frame fields are laid out MSB-first and shifted left by the byte counter.
  assign eth_hdr = {(type_q ? mac_q : 48'hffff_ffff_ffff), BOARD_MAC, ETH_TYPE_ARP};
  assign arp_pkt = {HARD_TYPE, PROTOCOL_TYPE, HARD_LEN, PROTO_LEN,
                    (type_q ? OP_REP : OP_REQ), BOARD_MAC, BOARD_IP,
                    (type_q ? mac_q : 48'h0), ip_q};
  assign eth_sh  = eth_hdr << {cnt_q, 3'b000};
  assign arp_sh  = arp_pkt << {cnt_q, 3'b000};
  assign fcs_sh  = ~crc_val >> {cnt_q, 3'b000};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 5'd1;
    type_d  = type_q;
    mac_d   = mac_q;
    ip_d    = ip_q;
    txen_d  = 1'b1;
    txd_d   = 8'h00;
    done_d  = 1'b0;
    crc_en  = 1'b0;
    crc_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        txen_d  = 1'b0;
        cnt_d   = 5'd0;
        crc_clr = 1'b1;
        if (arp_tx_en) begin
          state_d = ST_PREAMBLE;
          type_d  = arp_tx_type;
          mac_d   = (des_mac == 48'h0) ? DES_MAC : des_mac;
          ip_d    = (des_ip == 32'h0) ? DES_IP : des_ip;
        end
      end
      ST_PREAMBLE: begin
        txd_d = (cnt_q == PREAMBLE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
        if (cnt_q == PREAMBLE_LAST) begin
          state_d = ST_ETH_HEAD;
          cnt_d   = 5'd0;
        end
      end
      ST_ETH_HEAD: begin
        txd_d  = eth_sh[111:104];
        crc_en = 1'b1;
        if (cnt_q == ETH_HEAD_LAST) begin
          state_d = ST_ARP_DATA;
          cnt_d   = 5'd0;
        end
      end
      ST_ARP_DATA: begin
        txd_d  = arp_sh[223:216];
        crc_en = 1'b1;
        if (cnt_q == ARP_DATA_LAST) begin
          state_d = ST_PAD;
          cnt_d   = 5'd0;
        end
      end
      ST_PAD: begin
        crc_en = 1'b1;
        if (cnt_q == PAD_LAST) begin
          state_d = ST_FCS;
          cnt_d   = 5'd0;
        end
      end
      ST_FCS: begin
        txd_d = fcs_sh[7:0];
        if (cnt_q == FCS_LAST) begin
          done_d  = 1'b1;
          state_d = ST_IFG;
          cnt_d   = 5'd0;
        end
      end
      ST_IFG: begin
        txen_d = 1'b0;
        if (cnt_q == IFG_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 5'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txen_d  = 1'b0;
        cnt_d   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge gmii_tx_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      type_q  <= 1'b0;
      mac_q   <= DES_MAC;
      ip_q    <= DES_IP;
      txen_q  <= 1'b0;
      txd_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      mac_q   <= mac_d;
      ip_q    <= ip_d;
      txen_q  <= txen_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  crc32_d8 u_crc (
    .clk_i  (gmii_tx_clk),
    .rst_ni (rstn),
    .en_i   (crc_en),
    .clr_i  (crc_clr),
    .data_i (txd_d),
    .crc_o  (crc_val)
  );

  assign gmii_tx_en = txen_q;
  assign gmii_txd   = txd_q;
  assign tx_done    = done_q;
  assign tx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_arp_tx.sv
// Directed bench for arp_tx: frame content, FCS, timing, busy rejection,
// back-to-back spacing, mid-frame reset and zero-address fallback.
module tb_arp_tx;

  localparam logic [47:0] BOARD_MAC = 48'h12_34_56_78_9a_bc;
  localparam logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10};
  localparam logic [47:0] DES_MAC   = 48'ha1_b2_c3_d4_e5_f6;
  localparam logic [31:0] DES_IP    = {8'd10, 8'd0, 8'd0, 8'd1};

  logic        gmii_tx_clk = 1'b0;
  logic        rstn        = 1'b1;
  logic        arp_tx_en   = 1'b0;
  logic        arp_tx_type = 1'b0;
  logic [47:0] des_mac     = 48'h0;
  logic [31:0] des_ip      = 32'h0;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic        tx_busy;
  logic        tx_done;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] expFrame [72];
  logic [7:0] capFrame [128];
  int         capLen, capDone, capDoneCnt, capWait;
  bit         capGot;

  arp_tx #(
    .BOARD_MAC (BOARD_MAC),
    .BOARD_IP  (BOARD_IP),
    .DES_MAC   (DES_MAC),
    .DES_IP    (DES_IP)
  ) dut (
    .gmii_tx_clk (gmii_tx_clk),
    .rstn        (rstn),
    .arp_tx_en   (arp_tx_en),
    .arp_tx_type (arp_tx_type),
    .des_mac     (des_mac),
    .des_ip      (des_ip),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  always #4 gmii_tx_clk = ~gmii_tx_clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Golden CRC in the non-reflected, MSB-first shift-register form.
  function automatic logic [31:0] goldenFcs(input int first, input int last);
    logic [31:0] c;
    logic [31:0] r;
    logic [7:0]  b;
    c = 32'hffff_ffff;
    for (int i = first; i <= last; i++) begin
      b = expFrame[i];
      for (int k = 0; k < 8; k++) begin
        if (c[31] ^ b[k]) c = (c << 1) ^ 32'h04c1_1db7;
        else              c = c << 1;
      end
    end
    for (int k = 0; k < 32; k++) r[k] = c[31-k];
    return ~r;
  endfunction

  task automatic buildExpected(input bit t, input logic [47:0] mac, input logic [31:0] ip);
    logic [111:0] eth;
    logic [223:0] arp;
    logic [31:0]  fcs;
    eth = {(t ? mac : 48'hffff_ffff_ffff), BOARD_MAC, 16'h0806};
    arp = {16'h0001, 16'h0800, 8'h06, 8'h04, (t ? 16'h0002 : 16'h0001),
           BOARD_MAC, BOARD_IP, (t ? mac : 48'h0), ip};
    for (int i = 0; i < 7; i++) expFrame[i] = 8'h55;
    expFrame[7] = 8'hd5;
    for (int i = 0; i < 14; i++) expFrame[8+i] = eth[111-8*i -: 8];
    for (int i = 0; i < 28; i++) expFrame[22+i] = arp[223-8*i -: 8];
    for (int i = 50; i < 68; i++) expFrame[i] = 8'h00;
    fcs = goldenFcs(8, 67);
    for (int k = 0; k < 4; k++) expFrame[68+k] = fcs[8*k +: 8];
  endtask

  task automatic pulseStart(input bit t, input logic [47:0] mac, input logic [31:0] ip);
    @(negedge gmii_tx_clk);
    arp_tx_type = t;
    des_mac     = mac;
    des_ip      = ip;
    arp_tx_en   = 1'b1;
    @(negedge gmii_tx_clk);
    arp_tx_en   = 1'b0;
  endtask

  // Waits (bounded) for gmii_tx_en, then records every byte while it stays high.
  task automatic captureFrame(input int maxWait, input int injectAt);
    capLen = 0; capDone = -1; capDoneCnt = 0; capWait = 0; capGot = 1'b0;
    for (int i = 0; i < 128; i++) capFrame[i] = 8'hxx;
    while (capWait < maxWait) begin
      @(negedge gmii_tx_clk);
      if (gmii_tx_en) begin
        capGot = 1'b1;
        break;
      end
      capWait++;
      assertCount++;
      if (gmii_txd !== 8'h00) begin
        failCount++;
        $display("[TB] FAIL idle_txd: got %h expected 00", gmii_txd);
      end
    end
    while (capGot && gmii_tx_en && capLen < 128) begin
      capFrame[capLen] = gmii_txd;
      if (tx_done) begin
        capDone = capLen;
        capDoneCnt++;
      end
      capLen++;
      if (capLen == injectAt) begin
        arp_tx_type = ~arp_tx_type;
        des_mac     = 48'hdead_beef_0001;
        des_ip      = 32'h0102_0304;
        arp_tx_en   = 1'b1;
      end else begin
        arp_tx_en   = 1'b0;
      end
      @(negedge gmii_tx_clk);
    end
    arp_tx_en = 1'b0;
  endtask

  task automatic test_reset;
    #1 rstn = 1'b0;
    repeat (3) @(negedge gmii_tx_clk);
    assertCount++;
    if (gmii_tx_en !== 1'b0) begin failCount++; $display("[TB] FAIL reset_tx_en: got %b expected 0", gmii_tx_en); end
    assertCount++;
    if (gmii_txd !== 8'h00) begin failCount++; $display("[TB] FAIL reset_txd: got %h expected 00", gmii_txd); end
    assertCount++;
    if (tx_busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 0", tx_busy); end
    assertCount++;
    if (tx_done !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done: got %b expected 0", tx_done); end
    rstn = 1'b1;
    repeat (4) @(negedge gmii_tx_clk);
    assertCount++;
    if (gmii_tx_en !== 1'b0 || tx_busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL post_reset_idle: got en=%b busy=%b expected en=0 busy=0", gmii_tx_en, tx_busy);
    end
  endtask

  task automatic test_request;
    pulseStart(1'b0, 48'h0102_0304_0506, 32'hc0a8_0164);
    assertCount++;
    if (gmii_tx_en !== 1'b0 || tx_busy !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL req_start_latency: got en=%b busy=%b expected en=0 busy=1", gmii_tx_en, tx_busy);
    end
    captureFrame(20, -1);
    buildExpected(1'b0, 48'h0102_0304_0506, 32'hc0a8_0164);
    assertCount++;
    if (capWait !== 0) begin failCount++; $display("[TB] FAIL req_first_byte_cycle: got %0d expected 0", capWait); end
    assertCount++;
    if (capLen !== 72) begin failCount++; $display("[TB] FAIL req_length: got %0d expected 72", capLen); end
    assertCount++;
    if (capDone !== 71 || capDoneCnt !== 1) begin
      failCount++;
      $display("[TB] FAIL req_done: got pos=%0d count=%0d expected pos=71 count=1", capDone, capDoneCnt);
    end
    for (int i = 0; i < 72; i++) begin
      assertCount++;
      if (capFrame[i] !== expFrame[i]) begin
        failCount++;
        $display("[TB] FAIL req_byte %0d: got %h expected %h", i, capFrame[i], expFrame[i]);
      end
    end
    repeat (16) @(negedge gmii_tx_clk);
  endtask

  task automatic test_reply;
    pulseStart(1'b1, 48'h2c_f0_5d_32_f1_07, 32'hc0a8_0164);
    captureFrame(20, -1);
    buildExpected(1'b1, 48'h2c_f0_5d_32_f1_07, 32'hc0a8_0164);
    assertCount++;
    if (capLen !== 72 || capDone !== 71) begin
      failCount++;
      $display("[TB] FAIL rep_length: got len=%0d done=%0d expected len=72 done=71", capLen, capDone);
    end
    assertCount++;
    if (capFrame[8] !== 8'h2c || capFrame[13] !== 8'h07 || capFrame[29] !== 8'h02) begin
      failCount++;
      $display("[TB] FAIL rep_fields: got %h %h %h expected 2c 07 02", capFrame[8], capFrame[13], capFrame[29]);
    end
    for (int i = 0; i < 72; i++) begin
      assertCount++;
      if (capFrame[i] !== expFrame[i]) begin
        failCount++;
        $display("[TB] FAIL rep_byte %0d: got %h expected %h", i, capFrame[i], expFrame[i]);
      end
    end
    repeat (16) @(negedge gmii_tx_clk);
  endtask

  task automatic test_fallback;
    pulseStart(1'b1, 48'h0, 32'h0);
    captureFrame(20, -1);
    buildExpected(1'b1, DES_MAC, DES_IP);
    assertCount++;
    if (capLen !== 72) begin failCount++; $display("[TB] FAIL fb_length: got %0d expected 72", capLen); end
    assertCount++;
    if (capFrame[8] !== 8'ha1 || capFrame[13] !== 8'hf6 || capFrame[49] !== 8'h01) begin
      failCount++;
      $display("[TB] FAIL fb_fields: got %h %h %h expected a1 f6 01", capFrame[8], capFrame[13], capFrame[49]);
    end
    for (int i = 0; i < 72; i++) begin
      assertCount++;
      if (capFrame[i] !== expFrame[i]) begin
        failCount++;
        $display("[TB] FAIL fb_byte %0d: got %h expected %h", i, capFrame[i], expFrame[i]);
      end
    end
    repeat (16) @(negedge gmii_tx_clk);
  endtask

  task automatic test_busy_reject;
    pulseStart(1'b0, 48'h0a0b_0c0d_0e0f, 32'hc0a8_0199);
    captureFrame(20, 30);
    buildExpected(1'b0, 48'h0a0b_0c0d_0e0f, 32'hc0a8_0199);
    assertCount++;
    if (capLen !== 72 || capDoneCnt !== 1) begin
      failCount++;
      $display("[TB] FAIL busy_length: got len=%0d dones=%0d expected len=72 dones=1", capLen, capDoneCnt);
    end
    for (int i = 0; i < 72; i++) begin
      assertCount++;
      if (capFrame[i] !== expFrame[i]) begin
        failCount++;
        $display("[TB] FAIL busy_byte %0d: got %h expected %h", i, capFrame[i], expFrame[i]);
      end
    end
    repeat (9) @(negedge gmii_tx_clk);
    assertCount++;
    if (tx_busy !== 1'b1) begin failCount++; $display("[TB] FAIL busy_last_ifg: got %b expected 1", tx_busy); end
    arp_tx_type = 1'b1;
    des_mac     = 48'h2c_f0_5d_32_f1_07;
    arp_tx_en   = 1'b1;
    @(negedge gmii_tx_clk);
    arp_tx_en   = 1'b0;
    assertCount++;
    if (tx_busy !== 1'b0) begin failCount++; $display("[TB] FAIL busy_idle_entry: got %b expected 0", tx_busy); end
    captureFrame(40, -1);
    assertCount++;
    if (capGot !== 1'b0) begin failCount++; $display("[TB] FAIL busy_no_second_frame: got frame=%b expected 0", capGot); end
  endtask

  task automatic test_back_to_back;
    int gap;
    pulseStart(1'b0, 48'h0, 32'hc0a8_0101);
    captureFrame(20, -1);
    assertCount++;
    if (capLen !== 72) begin failCount++; $display("[TB] FAIL b2b_first_length: got %0d expected 72", capLen); end
    gap = 1;
    repeat (9) @(negedge gmii_tx_clk);
    gap += 9;
    @(negedge gmii_tx_clk);
    gap += 1;
    assertCount++;
    if (tx_busy !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_idle: got busy=%b expected 0", tx_busy); end
    arp_tx_type = 1'b1;
    des_mac     = 48'h2c_f0_5d_32_f1_07;
    des_ip      = 32'hc0a8_0102;
    arp_tx_en   = 1'b1;
    @(negedge gmii_tx_clk);
    arp_tx_en   = 1'b0;
    if (!gmii_tx_en) gap += 1;
    captureFrame(20, -1);
    gap += capWait;
    assertCount++;
    if (gap !== 12) begin failCount++; $display("[TB] FAIL b2b_gap: got %0d expected 12", gap); end
    buildExpected(1'b1, 48'h2c_f0_5d_32_f1_07, 32'hc0a8_0102);
    assertCount++;
    if (capLen !== 72 || capDone !== 71) begin
      failCount++;
      $display("[TB] FAIL b2b_second_length: got len=%0d done=%0d expected len=72 done=71", capLen, capDone);
    end
    for (int i = 0; i < 72; i++) begin
      assertCount++;
      if (capFrame[i] !== expFrame[i]) begin
        failCount++;
        $display("[TB] FAIL b2b_byte %0d: got %h expected %h", i, capFrame[i], expFrame[i]);
      end
    end
    repeat (16) @(negedge gmii_tx_clk);
  endtask

  task automatic test_reset_midframe;
    int waitCnt;
    int enSeen;
    pulseStart(1'b0, 48'h0, 32'hc0a8_0164);
    waitCnt = 0;
    while (!gmii_tx_en && waitCnt < 20) begin
      @(negedge gmii_tx_clk);
      waitCnt++;
    end
    assertCount++;
    if (gmii_tx_en !== 1'b1) begin failCount++; $display("[TB] FAIL rst_frame_start: got %b expected 1", gmii_tx_en); end
    repeat (39) @(negedge gmii_tx_clk);
    #1 rstn = 1'b0;
    #1;
    assertCount++;
    if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL rst_async_out: got en=%b txd=%h expected en=0 txd=00", gmii_tx_en, gmii_txd);
    end
    assertCount++;
    if (tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rst_async_status: got busy=%b done=%b expected 0 0", tx_busy, tx_done);
    end
    @(negedge gmii_tx_clk);
    rstn = 1'b1;
    enSeen = 0;
    repeat (100) begin
      @(negedge gmii_tx_clk);
      if (gmii_tx_en) enSeen++;
    end
    assertCount++;
    if (enSeen !== 0) begin failCount++; $display("[TB] FAIL rst_truncated: got %0d active cycles expected 0", enSeen); end
    pulseStart(1'b1, 48'h2c_f0_5d_32_f1_07, 32'hc0a8_0164);
    captureFrame(20, -1);
    buildExpected(1'b1, 48'h2c_f0_5d_32_f1_07, 32'hc0a8_0164);
    assertCount++;
    if (capLen !== 72 || capDone !== 71) begin
      failCount++;
      $display("[TB] FAIL rst_next_length: got len=%0d done=%0d expected len=72 done=71", capLen, capDone);
    end
    for (int i = 0; i < 72; i++) begin
      assertCount++;
      if (capFrame[i] !== expFrame[i]) begin
        failCount++;
        $display("[TB] FAIL rst_next_byte %0d: got %h expected %h", i, capFrame[i], expFrame[i]);
      end
    end
    repeat (16) @(negedge gmii_tx_clk);
  endtask

  initial begin
    $display("[TB] arp_tx directed test start");
    test_reset();
    test_request();
    test_reply();
    test_fallback();
    test_busy_reject();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
